// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use stall and multi-cycle EX hold
// for the five-stage pipeline, driven from two shadow destination slots.
module fwd_hazard_unit #(
    parameter int MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs_field,
    input  logic [4:0] id_rt_field,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_valid,
    input  logic [4:0] ex_rs_field,
    input  logic [4:0] ex_rt_field,
    input  logic [4:0] ex_regdst,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic       ex_multicycle,
    input  logic       flush,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       stall,
    output logic       ex_hold,
    output logic       id_ex_bubble
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam bit MC_EN = (MUL_LATENCY > 1);
    localparam logic [3:0] CNT_INIT =
        MC_EN ? 4'(MUL_LATENCY - 2) : 4'd0;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    logic       mem_valid;
    logic       mem_regwrite;
    logic       mem_memread;
    logic [4:0] mem_dst;
    logic       wb_valid;
    logic       wb_regwrite;
    logic [4:0] wb_dst;

    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       wb_hit_a;
    logic       wb_hit_b;
    logic       lu_src;
    logic       lu;
    logic       mc_req;
    logic       hold;
    logic       lu_stall;

    function automatic logic hit(
        input logic       v,
        input logic       w,
        input logic [4:0] d,
        input logic [4:0] src
    );
        return v & w & (d != 5'd0) & (d == src);
    endfunction

    assign mem_hit_a = hit(mem_valid, mem_regwrite, mem_dst, ex_rs_field);
    assign mem_hit_b = hit(mem_valid, mem_regwrite, mem_dst, ex_rt_field);
    assign wb_hit_a  = hit(wb_valid, wb_regwrite, wb_dst, ex_rs_field);
    assign wb_hit_b  = hit(wb_valid, wb_regwrite, wb_dst, ex_rt_field);

    // Newest producer (MEM) wins when both slots hold the same register.
    always_comb begin
        forward_a = 2'b00;
        priority case (1'b1)
            mem_hit_a: forward_a = 2'b01;
            wb_hit_a:  forward_a = 2'b10;
            default:   forward_a = 2'b00;
        endcase
    end

    always_comb begin
        forward_b = 2'b00;
        priority case (1'b1)
            mem_hit_b: forward_b = 2'b01;
            wb_hit_b:  forward_b = 2'b10;
            default:   forward_b = 2'b00;
        endcase
    end

    assign lu_src = (id_use_rs & (id_rs_field == ex_regdst))
                  | (id_use_rt & (id_rt_field == ex_regdst));

    assign lu = (state == IDLE) & ex_valid & ex_memread
              & ex_regwrite & (ex_regdst != 5'd0) & lu_src;

    assign mc_req = MC_EN & ex_valid & ex_multicycle;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hold     = 1'b0;
        lu_stall = 1'b0;
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mc_req) begin
                        hold     = 1'b1;
                        state_nx = BUSY;
                        cnt_nx   = CNT_INIT;
                    end else if (lu) begin
                        lu_stall = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        hold   = 1'b1;
                        cnt_nx = cnt - 4'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever EX presents.
    assign stall        = rst_n & (hold | lu_stall);
    assign ex_hold      = rst_n & hold;
    assign id_ex_bubble = rst_n & lu_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_dst      <= 5'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_dst       <= 5'd0;
        end else begin
            mem_valid    <= ex_valid & ~flush & ~hold;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_dst      <= ex_regdst;
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_dst       <= mem_dst;
        end
    end

    // A load still in MEM has no data yet; the load-use stall keeps
    // its consumer out of EX for that cycle.
    a_no_mem_load_fwd: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(mem_memread & (mem_hit_a | mem_hit_b))
    );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs_field;
    logic [4:0] id_rt_field;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_valid;
    logic [4:0] ex_rs_field;
    logic [4:0] ex_rt_field;
    logic [4:0] ex_regdst;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_multicycle;
    logic       flush;
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic       stall;
    logic       ex_hold;
    logic       id_ex_bubble;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.MUL_LATENCY(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs_field  (id_rs_field),
        .id_rt_field  (id_rt_field),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_valid     (ex_valid),
        .ex_rs_field  (ex_rs_field),
        .ex_rt_field  (ex_rt_field),
        .ex_regdst    (ex_regdst),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_multicycle(ex_multicycle),
        .flush        (flush),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .ex_hold      (ex_hold),
        .id_ex_bubble (id_ex_bubble)
    );

    typedef struct packed {
        logic       rst_n;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       use_rs;
        logic       use_rt;
        logic       ex_valid;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_dst;
        logic       rw;
        logic       mr;
        logic       mc;
        logic       flush;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] v;
    } exp_t;

    vec_t       nv;
    exp_t       exp_q[$];
    exp_t       e;
    logic [6:0] act;
    int         total = 0;
    int         bad = 0;

    task automatic clr();
        nv = '0;
        nv.rst_n = 1'b1;
    endtask

    task automatic set_ex(input int v, input int rw, input int mr,
                          input int mc, input int dst, input int rs,
                          input int rt);
        clr();
        nv.ex_valid = 1'(v);
        nv.rw       = 1'(rw);
        nv.mr       = 1'(mr);
        nv.mc       = 1'(mc);
        nv.ex_dst   = 5'(dst);
        nv.ex_rs    = 5'(rs);
        nv.ex_rt    = 5'(rt);
    endtask

    task automatic set_id(input int ur, input int r,
                          input int ut, input int t);
        nv.use_rs = 1'(ur);
        nv.id_rs  = 5'(r);
        nv.use_rt = 1'(ut);
        nv.id_rt  = 5'(t);
    endtask

    task automatic apply();
        rst_n         = nv.rst_n;
        id_rs_field   = nv.id_rs;
        id_rt_field   = nv.id_rt;
        id_use_rs     = nv.use_rs;
        id_use_rt     = nv.use_rt;
        ex_valid      = nv.ex_valid;
        ex_rs_field   = nv.ex_rs;
        ex_rt_field   = nv.ex_rt;
        ex_regdst     = nv.ex_dst;
        ex_regwrite   = nv.rw;
        ex_memread    = nv.mr;
        ex_multicycle = nv.mc;
        flush         = nv.flush;
    endtask

    task automatic step(input string name, input int fa, input int fb,
                        input int st, input int ho, input int bu);
        exp_t x;
        @(posedge clk);
        #1;
        apply();
        x.name = name;
        x.v = {2'(fa), 2'(fb), 1'(st), 1'(ho), 1'(bu)};
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act = {forward_a, forward_b, stall, ex_hold, id_ex_bubble};
            total++;
            if (act !== e.v)
                begin
                    bad++;
                    $display("FAIL %s: got fa=%b fb=%b st=%b ho=%b bu=%b want fa=%b fb=%b st=%b ho=%b bu=%b",
                             e.name, act[6:5], act[4:3], act[2], act[1],
                             act[0], e.v[6:5], e.v[4:3], e.v[2], e.v[1],
                             e.v[0]);
                end
        end
    end

    initial begin
        clr();
        nv.rst_n = 1'b0;
        apply();

        set_ex(1, 1, 1, 1, 3, 3, 3); set_id(1, 3, 1, 3); nv.rst_n = 1'b0;
        step("rst_hold0", 0, 0, 0, 0, 0);
        step("rst_hold1", 0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0, 0, 3, 3);
        step("rst_release", 0, 0, 0, 0, 0);

        set_ex(1, 1, 0, 0, 5, 0, 0); step("fwd_prod", 0, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 5, 0); step("fwd_mem_a", 1, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 0, 5); step("fwd_wb_b", 0, 2, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 5, 5); step("fwd_rf", 0, 0, 0, 0, 0);

        set_ex(1, 1, 0, 0, 7, 0, 0); step("pri_p0", 0, 0, 0, 0, 0);
        set_ex(1, 1, 0, 0, 7, 7, 0); step("pri_p1", 1, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 7, 7); step("pri_mem_wins", 1, 1, 0, 0, 0);
        set_ex(1, 1, 0, 0, 0, 7, 0); step("pri_wb_only", 2, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 0, 0); step("r0_no_fwd", 0, 0, 0, 0, 0);

        set_ex(1, 1, 1, 0, 3, 0, 0); set_id(1, 3, 0, 0);
        step("lu_rs", 0, 0, 1, 0, 1);
        set_ex(0, 0, 0, 0, 0, 0, 0); set_id(1, 3, 0, 0);
        step("lu_bubble", 0, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 3, 0); step("lu_consumer", 2, 0, 0, 0, 0);
        set_ex(1, 1, 1, 0, 4, 0, 0); set_id(0, 4, 0, 4);
        step("lu_unused", 0, 0, 0, 0, 0);
        set_ex(1, 1, 1, 0, 6, 0, 0); set_id(0, 0, 1, 6);
        step("lu_rt", 0, 0, 1, 0, 1);
        set_ex(0, 1, 0, 0, 8, 0, 0); step("inv_writer", 0, 0, 0, 0, 0);
        set_ex(1, 1, 1, 0, 0, 8, 8); set_id(1, 0, 0, 0);
        step("inv_slot_r0_load", 0, 0, 0, 0, 0);

        set_ex(1, 1, 0, 1, 9, 0, 0); step("mc_c0", 0, 0, 1, 1, 0);
        step("mc_c1", 0, 0, 1, 1, 0);
        set_ex(1, 1, 1, 1, 9, 0, 0); set_id(1, 9, 0, 0);
        step("mc_c2_lu_masked", 0, 0, 1, 1, 0);
        set_ex(1, 1, 0, 1, 9, 0, 0); step("mc_c3_release", 0, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 9, 0); step("mc_consumer", 1, 0, 0, 0, 0);

        set_ex(1, 1, 0, 1, 11, 0, 0); step("fl_c0", 0, 0, 1, 1, 0);
        step("fl_c1", 0, 0, 1, 1, 0);
        nv.flush = 1'b1; step("fl_busy", 0, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 11, 11); step("fl_consumer", 0, 0, 0, 0, 0);
        set_ex(1, 1, 1, 0, 2, 0, 0); set_id(1, 2, 0, 0);
        step("fl_idle_lu", 0, 0, 1, 0, 1);
        nv.flush = 1'b1; step("fl_over_lu", 0, 0, 0, 0, 0);
        set_ex(1, 0, 0, 0, 0, 2, 0); step("fl_wb_fwd", 2, 0, 0, 0, 0);

        set_ex(1, 1, 0, 1, 13, 0, 0); step("rb_start", 0, 0, 1, 1, 0);
        nv.rst_n = 1'b0; step("rb_reset", 0, 0, 0, 0, 0);
        set_ex(1, 1, 1, 0, 2, 0, 0); set_id(1, 2, 0, 0);
        step("rb_idle", 0, 0, 1, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
